// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the SPRAM arbiter: FSM encoding, read-tag layout
// and the round-robin pick function.
package spram_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int NREQ_MAX   = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rd_tag_t;

  // One-hot of the first set bit of valid at or after ptr, wrapping at nreq.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                  input logic [2:0] ptr,
                                                  input int nreq);
    logic [NREQ_MAX-1:0] grant;
    logic                found;
    logic [2:0]          idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = 3'((int'(ptr) + k) % nreq);
      if (k < nreq && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/spram_arbiter_rr_arbiter.sv
// Round-robin grant: combinational one-hot grant from valid and ptr, with ptr
// advancing past the granted requester on every handshake.
module rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NREQ-1:0]  valid,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             hs
);

  logic [IDX_W-1:0]    ptr;
  logic [NREQ_MAX-1:0] pick;
  logic                pick_unused;

  always_comb begin
    pick      = rr_pick(NREQ_MAX'(valid), 3'(ptr), NREQ);
    grant     = en ? pick[NREQ-1:0] : '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  // Bits above NREQ are always zero from rr_pick.
  assign pick_unused = ^pick;
  assign hs          = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port SPRAM between NREQ requesters: zero-fill after reset,
// then round-robin one command per cycle with tagged read returns.
//
//   state    | meaning
//   ST_CLEAR | writing zero to words 0..CLEAR_WORDS-1, requests held off
//   ST_RUN   | arbitrating requesters, one SPRAM command per cycle
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_LAT      = 2,
  parameter int CLEAR_WORDS = 16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   init_done,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_wren,
  input  logic [DATA_W-1:0]      ram_rdata
);

  localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CLR_LAST = (CLEAR_WORDS > 0) ? CLEAR_WORDS - 1 : 0;
  localparam int TAG_D    = RD_LAT - 1;
  localparam arb_state_t ST_RESET = (CLEAR_WORDS == 0) ? ST_RUN : ST_CLEAR;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              hs;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rd_tag_t           tag_in;
  rd_tag_t           tag_pipe [TAG_D];
  logic [DATA_W-1:0] rdata_d;

  assign clr_last = (clr_cnt == ADDR_W'(CLR_LAST));

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_last) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
      if (state_q == ST_RUN) init_done <= 1'b1;
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_RUN),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .hs        (hs)
  );

  assign req_ready = grant;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_we    = req_we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      ram_addr  <= clr_cnt;
      ram_wdata <= '0;
      ram_wren  <= 1'b1;
    end else if (hs) begin
      ram_addr  <= sel_addr;
      ram_wdata <= sel_wdata;
      ram_wren  <= sel_we;
    end else begin
      ram_wren  <= 1'b0;
    end
  end

  always_comb begin
    tag_in.valid = hs & ~sel_we;
    tag_in.idx   = 3'(grant_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAG_D; i++) tag_pipe[i] <= '0;
      rsp_valid <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < TAG_D; i++) tag_pipe[i] <= tag_pipe[i-1];
      rsp_valid <= tag_pipe[TAG_D-1].valid ? (NREQ'(1) << tag_pipe[TAG_D-1].idx) : '0;
    end
  end

  // SPRAM DATAOUT is already two cycles behind the handshake, so the data path
  // only needs RD_LAT-2 extra stages to line up with the registered rsp_valid.
  generate
    if (RD_LAT == 2) begin : g_rdata_direct
      assign rdata_d = ram_rdata;
    end else begin : g_rdata_pipe
      logic [DATA_W-1:0] rdata_pipe [RD_LAT-2];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT - 2; i++) rdata_pipe[i] <= '0;
        end else begin
          rdata_pipe[0] <= ram_rdata;
          for (int i = 1; i < RD_LAT - 2; i++) rdata_pipe[i] <= rdata_pipe[i-1];
        end
      end
      assign rdata_d = rdata_pipe[RD_LAT-3];
    end
  endgenerate

  assign rsp_rdata = (|rsp_valid) ? rdata_d : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural 1-cycle SPRAM model.
module tb_spram_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   init_done;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_wdata;
  logic                   ram_wren;
  logic [DATA_W-1:0]      ram_rdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_total = 0;
  int n_bad   = 0;

  spram_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .CLEAR_WORDS(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    else          ram_rdata     <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_we[i]                  = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // reset state and CLEAR sequence
    tick;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1 chk("clr_ready_c0", req_ready, 0);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("clr_wren", ram_wren, 1);
      chk("clr_addr", ram_addr, k);
      chk("clr_wdata", ram_wdata, 0);
      if (k < 7) chk("clr_ready", req_ready, 0);
      if (k < 7) chk("clr_init_low", init_done, 0);
      if (k == 6) req_valid = '0;
    end
    chk("clr_init_c8", init_done, 0);
    tick;
    chk("clr_init_done", init_done, 1);
    chk("clr_wren_off", ram_wren, 0);

    // single write then read by req0, ptr=0
    set_req(0, 1'b1, 14'h0040, 16'h1234);
    req_valid = 4'b0001;
    #1 chk("wr_ready", req_ready, 4'b0001);
    tick;
    chk("wr_cmd_wren", ram_wren, 1);
    chk("wr_cmd_addr", ram_addr, 14'h0040);
    chk("wr_cmd_wdata", ram_wdata, 16'h1234);
    set_req(0, 1'b0, 14'h0040, 16'h0000);
    #1 chk("rd_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    chk("rd_rsp_t1", rsp_valid, 0);
    chk("rd_cmd_wren", ram_wren, 0);
    tick;
    chk("rd_rsp_valid", rsp_valid, 4'b0001);
    chk("rd_rsp_rdata", rsp_rdata, 16'h1234);
    tick;
    chk("rd_rsp_pulse", rsp_valid, 0);

    // req3 write brings ptr back to 0
    set_req(3, 1'b1, 14'h0300, 16'h3333);
    req_valid = 4'b1000;
    #1 chk("p3_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;

    // all four valid for 8 cycles: 0,1,2,3,0,1,2,3 back to back
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 14'(14'h0100 + i), 16'(16'hB000 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_ready", req_ready, 4'b0001 << (k % 4));
      tick;
      chk("rr_wren", ram_wren, 1);
      chk("rr_addr", ram_addr, 14'h0100 + (k % 4));
    end
    req_valid = '0;

    // preload 0xAAAA @5 and 0x5555 @9, then reads from req1 and req3
    set_req(0, 1'b1, 14'd5, 16'hAAAA);
    req_valid = 4'b0001;
    #1 chk("pl_ready0", req_ready, 4'b0001);
    tick;
    set_req(0, 1'b1, 14'd9, 16'h5555);
    #1 chk("pl_ready1", req_ready, 4'b0001);
    tick;
    set_req(1, 1'b0, 14'd5, 16'h0000);
    set_req(3, 1'b0, 14'd9, 16'h0000);
    req_valid = 4'b1010;
    #1 chk("rd2_ready_a", req_ready, 4'b0010);
    tick;
    req_valid = 4'b1000;
    #1 chk("rd2_ready_b", req_ready, 4'b1000);
    chk("rd2_rsp_early", rsp_valid, 0);
    tick;
    req_valid = '0;
    chk("rd2_rsp1_valid", rsp_valid, 4'b0010);
    chk("rd2_rsp1_data", rsp_rdata, 16'hAAAA);
    tick;
    chk("rd2_rsp3_valid", rsp_valid, 4'b1000);
    chk("rd2_rsp3_data", rsp_rdata, 16'h5555);
    tick;
    chk("rd2_rsp_idle", rsp_valid, 0);

    // only req2 valid: granted every cycle, ptr ends at 3
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      set_req(2, 1'b1, 14'(14'h0200 + k), 16'(16'h2220 + k));
      #1 chk("solo_ready", req_ready, 4'b0100);
      tick;
      chk("solo_wren", ram_wren, 1);
      chk("solo_wdata", ram_wdata, 16'h2220 + k);
    end
    req_valid = 4'b1111;
    #1 chk("solo_ptr3", req_ready, 4'b1000);
    req_valid = '0;

    // reset one cycle after a read handshake
    set_req(0, 1'b0, 14'h0040, 16'h0000);
    req_valid = 4'b0001;
    #1 chk("mr_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    rst       = 1'b1;
    tick;
    rst = 1'b0;
    chk("mr_rsp_kill", rsp_valid, 0);
    chk("mr_init_low", init_done, 0);
    chk("mr_wren_rst", ram_wren, 0);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("mr_clr_addr", ram_addr, k);
      chk("mr_clr_wren", ram_wren, 1);
      chk("mr_rsp_none", rsp_valid, 0);
    end
    tick;
    chk("mr_init_done", init_done, 1);
    req_valid = 4'b1111;
    #1 chk("mr_ptr0", req_ready, 4'b0001);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
